router_1xn_core: RTL and testbench
==================================

Name: router_1xn_core

Overview:
Parametrised 1-to-N packet router core, the successor to the fixed 1x3 router. It takes a byte-serial packet stream on a single write port and decodes the destination from the header. Each packet goes into one of N per-port output FIFOs, which read-side agents drain independently. New over the 1x3 generation: generic port count, data width and FIFO depth; length-counted framing; invalid-address drop; configurable soft-reset timeout.

Parameters:
NUM_PORTS, 3, number of output ports (2..8)
DATA_WIDTH, 8, byte width of data_in/data_out
FIFO_DEPTH, 16, entries per output FIFO (power of 2, >=4)
TIMEOUT, 30, idle cycles with vld_out high and no read_enb before that FIFO is flushed

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high reset
pkt_valid  in  1  data_in carries a packet byte this cycle
data_in  in  DATA_WIDTH  packet byte
busy  out  1  core cannot accept data_in this cycle
err  out  1  one-cycle pulse: parity mismatch or invalid address
read_enb  in  NUM_PORTS  per-port pop request
vld_out  out  NUM_PORTS  per-port FIFO non-empty
data_out  out  NUM_PORTS*DATA_WIDTH  per-port FIFO head; port i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Packet = header, L payload bytes, parity byte; pkt_valid high for every byte. Header: addr = data_in[ADDR_W-1:0], ADDR_W = $clog2(NUM_PORTS); L = data_in[DATA_WIDTH-1:ADDR_W]. L=0 is legal (header then parity).
- Byte accepted at posedge iff pkt_valid && !busy. Bytes with pkt_valid=0 are ignored. busy is combinational from state and FIFO flags.
- Parity = XOR of header and all payload bytes, compared with the received parity byte.
- Reset (synchronous): state IDLE, all FIFOs empty, counters 0, busy=0, err=0, vld_out=0, data_out=0.
- FSM states:
  - IDLE:
    - Header with addr < NUM_PORTS and dest FIFO not full: write header; latch dest, L and parity; go to LOAD (L>0) or PARITY (L=0).
    - Header with addr >= NUM_PORTS: go to DROP.
    - Dest FIFO full: busy=1, header not accepted.
  - LOAD: write payload and decrement the count; at count 1 go to PARITY. busy = dest FIFO full.
  - PARITY: write the parity byte to the FIFO, go to CHECK. busy = dest FIFO full.
  - CHECK (1 cycle): busy=1; err=1 on the next cycle if mismatch; go to IDLE.
  - DROP: consume L+1 bytes, never busy, write nothing. On the last byte, err pulses on the next cycle; go to IDLE.
- A packet with a parity error is still delivered whole, parity byte included.
- FIFO: first-word-fall-through. A byte written into an empty FIFO at edge t shows on data_out with vld_out=1 after edge t.
  - read_enb[i] with vld_out[i]=1 pops at the edge; read_enb when empty is ignored.
  - Read and write together: both happen, count unchanged. A write when full is impossible because busy blocks it.
- Soft reset per port: counter increments while vld_out[i] && !read_enb[i] and clears otherwise. On reaching TIMEOUT, FIFO i is flushed on that edge (vld_out[i]=0 next cycle) and the counter clears.
  - A flush does not abort a packet in flight to that port: remaining bytes are still written.
  - Flush and write on the same edge: flush wins, the write lands in the now-empty FIFO.
- Reset mid-packet: the packet is discarded and the next byte is treated as a header.
- Unused data_out lanes of empty FIFOs hold their last value.

Decomposition:
- router_pkg: state enum (IDLE, LOAD, PARITY, CHECK, DROP); localparams ADDR_W and LEN_W = DATA_WIDTH-ADDR_W; header field-extract functions.
- Sub-module router_fifo (sync FWFT, WIDTH/DEPTH params, flush input, full/empty flags), instantiated NUM_PORTS times by generate loop.
- FSM, parity and timeout counters live in the top.

Test Plan:
- Defaults. Send 0D,11,22,33,0D (addr 1, L=3, parity 0D) with read_enb=0 -> vld_out[1] rises after header edge, data_out[1]=0D; popping 5x yields 0D,11,22,33,0D; err stays 0; vld_out[0],[2] stay 0.
- Same packet with parity 00 -> 5 bytes in FIFO 1; err=1 for exactly one cycle, the cycle after CHECK.
- Header 07 (addr 3, L=1), 55, 52 -> busy never asserts, all vld_out stay 0, one err pulse, next header 04 (addr 0, L=1) routes to port 0.
- Port 0, header with L=20, no reads -> busy=1 after the 16th accepted byte; one read_enb[0] pulse lets exactly one more byte in; full drain completes the packet with err=0.
- Write a 2-byte packet to port 2, hold read_enb[2]=0 -> vld_out[2] drops after exactly 30 idle cycles. Repeat with read_enb[2] asserted at cycle 29 -> no flush.
- Assert reset for one cycle mid-payload -> all vld_out=0, busy=0 next cycle; a fresh packet is then routed correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and helpers for the 1-to-N packet router.
//   state_t      : receive FSM states
//   ADDR_W/LEN_W : header field widths for the default 3-port, 8-bit build
//   calc_addr_w  : address field width for a given port count
//   hdr_addr/len : split a header byte into its address and length fields
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PARITY,
    ST_CHECK,
    ST_DROP
  } state_t;

  localparam int DEF_NUM_PORTS  = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int ADDR_W         = $clog2(DEF_NUM_PORTS);
  localparam int LEN_W          = DEF_DATA_WIDTH - ADDR_W;

  function automatic int calc_addr_w(input int num_ports);
    return $clog2(num_ports);
  endfunction

  // Low addr_w bits of the header select the destination port.
  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  // Remaining upper bits of the header are the payload length.
  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_w);
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous first-word-fall-through FIFO with a flush input.
//   clk, reset : clock and synchronous active-high reset
//   flush      : empty the FIFO at this edge (a same-edge write still lands)
//   wr_en/data : push request and data
//   rd_en      : pop request, ignored while empty
//   rd_data    : registered head of the queue; holds its last value when empty
//   full/empty : occupancy flags
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             push;
  logic             pop;
  logic [PW-1:0]    rd_ptr_inc;

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign push       = wr_en && (flush || !full);
  assign pop        = rd_en && !empty && !flush;
  assign rd_ptr_inc = rd_ptr_reg + PW'(1);
  assign rd_data    = head_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // head_reg is the registered read port: it is loaded either straight from
  // the write data (writing into an empty or emptying FIFO) or from the entry
  // behind the current head when popping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (flush) begin
        rd_ptr_reg <= wr_ptr_reg;
        count_reg  <= push ? CW'(1) : '0;
        if (push) begin
          head_reg <= wr_data;
        end
      end else begin
        if (pop) begin
          rd_ptr_reg <= rd_ptr_inc;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
        if (push && (empty || (count_reg == CW'(1) && pop))) begin
          head_reg <= wr_data;
        end else if (pop && count_reg > CW'(1)) begin
          head_reg <= mem[rd_ptr_inc];
        end
      end
    end
  end

endmodule

// File: rtl/router_1xn_core.sv
// 1-to-N packet router core.
// A byte-serial packet (header, L payload bytes, parity byte) arrives on
// data_in and is steered whole into the output FIFO chosen by the header
// address. Packets to a non-existent port are consumed and flagged on err.
//   clk, reset : clock and synchronous active-high reset
//   pkt_valid  : data_in carries a packet byte
//   data_in    : packet byte
//   busy       : byte on data_in is not accepted this cycle
//   err        : one-cycle pulse for parity mismatch or invalid address
//   read_enb   : per-port pop request
//   vld_out    : per-port FIFO non-empty
//   data_out   : per-port FIFO head, port i at [i*DATA_WIDTH +: DATA_WIDTH]
module router_1xn_core
  import router_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pkt_valid,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic                            busy,
  output logic                            err,
  input  logic [NUM_PORTS-1:0]            read_enb,
  output logic [NUM_PORTS-1:0]            vld_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out
);

  localparam int AW = calc_addr_w(NUM_PORTS);
  localparam int LW = DATA_WIDTH - AW;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state_reg, state_next;
  logic [AW-1:0]         dest_reg, dest_next;
  logic [LW:0]           cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] par_reg, par_next;
  logic                  mism_reg, mism_next;
  logic                  err_reg, err_next;

  logic [NUM_PORTS-1:0]  fifo_full;
  logic [NUM_PORTS-1:0]  fifo_empty;
  logic [NUM_PORTS-1:0]  fifo_wr;
  logic [NUM_PORTS-1:0]  fifo_flush;

  logic [AW-1:0]         hdr_addr_w;
  logic [LW:0]           hdr_len_w;
  logic                  hdr_ok;

  // Length is held one bit wider than the header field so DROP can count L+1.
  assign hdr_addr_w = AW'(hdr_addr(32'(data_in), AW));
  assign hdr_len_w  = (LW + 1)'(hdr_len(32'(data_in), AW));
  assign hdr_ok     = (int'(hdr_addr_w) < NUM_PORTS);
  assign err        = err_reg;

  always_comb begin
    state_next = state_reg;
    dest_next  = dest_reg;
    cnt_next   = cnt_reg;
    par_next   = par_reg;
    mism_next  = mism_reg;
    err_next   = 1'b0;
    busy       = 1'b0;
    fifo_wr    = '0;
    case (state_reg)
      ST_IDLE: begin
        busy = pkt_valid && hdr_ok && fifo_full[hdr_addr_w];
        if (pkt_valid && !busy) begin
          if (hdr_ok) begin
            fifo_wr[hdr_addr_w] = 1'b1;
            dest_next  = hdr_addr_w;
            cnt_next   = hdr_len_w;
            par_next   = data_in;
            state_next = (hdr_len_w == '0) ? ST_PARITY : ST_LOAD;
          end else begin
            cnt_next   = hdr_len_w + (LW + 1)'(1);
            state_next = ST_DROP;
          end
        end
      end
      ST_LOAD: begin
        busy = fifo_full[dest_reg];
        if (pkt_valid && !busy) begin
          fifo_wr[dest_reg] = 1'b1;
          par_next = par_reg ^ data_in;
          cnt_next = cnt_reg - (LW + 1)'(1);
          if (cnt_reg == (LW + 1)'(1)) begin
            state_next = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        busy = fifo_full[dest_reg];
        if (pkt_valid && !busy) begin
          // The parity byte is delivered even when it does not match.
          fifo_wr[dest_reg] = 1'b1;
          mism_next  = (par_reg != data_in);
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        busy       = 1'b1;
        err_next   = mism_reg;
        state_next = ST_IDLE;
      end
      ST_DROP: begin
        if (pkt_valid) begin
          cnt_next = cnt_reg - (LW + 1)'(1);
          if (cnt_reg == (LW + 1)'(1)) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      dest_reg  <= '0;
      cnt_reg   <= '0;
      par_reg   <= '0;
      mism_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dest_reg  <= dest_next;
      cnt_reg   <= cnt_next;
      par_reg   <= par_next;
      mism_reg  <= mism_next;
      err_reg   <= err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [TW-1:0] to_cnt_reg;
      logic          stale;

      // A port is stale while it holds data nobody reads; after TIMEOUT such
      // cycles in a row its FIFO is flushed.
      assign stale          = !fifo_empty[gi] && !read_enb[gi];
      assign fifo_flush[gi] = stale && (to_cnt_reg == TW'(TIMEOUT - 1));
      assign vld_out[gi]    = !fifo_empty[gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          to_cnt_reg <= '0;
        end else if (stale && !fifo_flush[gi]) begin
          to_cnt_reg <= to_cnt_reg + TW'(1);
        end else begin
          to_cnt_reg <= '0;
        end
      end

      router_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
      ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (fifo_flush[gi]),
        .wr_en  (fifo_wr[gi]),
        .wr_data(data_in),
        .rd_en  (read_enb[gi]),
        .rd_data(data_out[gi*DATA_WIDTH +: DATA_WIDTH]),
        .full   (fifo_full[gi]),
        .empty  (fifo_empty[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_router_1xn_core.sv
// Directed testbench for router_1xn_core with default parameters.
module tb_router_1xn_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic        busy;
  logic        err;
  logic [2:0]  read_enb;
  logic [2:0]  vld_out;
  logic [23:0] data_out;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
  end

  router_1xn_core dut (
    .clk      (clk),
    .reset    (reset),
    .pkt_valid(pkt_valid),
    .data_in  (data_in),
    .busy     (busy),
    .err      (err),
    .read_enb (read_enb),
    .vld_out  (vld_out),
    .data_out (data_out)
  );

  function automatic logic [7:0] lane(input int p);
    return data_out[p*8 +: 8];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    pkt_valid = 1'b1;
    data_in   = b;
    while (busy && n < 64) begin
      tick;
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $error("FAIL send_stall observed=busy expected=accept byte=%02h", b);
    end
    tick;
    pkt_valid = 1'b0;
    $display("send byte=%02h", b);
  endtask

  task automatic pop(input int p, input logic [7:0] exp, input string tag);
    chk({tag, "_vld"}, 32'(vld_out[p]), 32'd1);
    chk({tag, "_data"}, 32'(lane(p)), 32'(exp));
    read_enb[p] = 1'b1;
    tick;
    read_enb[p] = 1'b0;
    $display("pop port=%0d byte=%02h", p, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    read_enb  = 3'b000;
    tick;
    tick;
    reset = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_vld", 32'(vld_out), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);

    // Good packet to port 1: 0D 11 22 33 0D
    send(8'h0D);
    chk("t1_vld_hdr", 32'(vld_out), 32'b010);
    chk("t1_head", 32'(lane(1)), 32'h0D);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h0D);
    chk("t1_check_busy", 32'(busy), 32'd1);
    tick;
    chk("t1_err_a", 32'(err), 32'd0);
    tick;
    chk("t1_err_b", 32'(err), 32'd0);
    chk("t1_vld_only1", 32'(vld_out), 32'b010);
    pop(1, 8'h0D, "t1_p0");
    pop(1, 8'h11, "t1_p1");
    pop(1, 8'h22, "t1_p2");
    pop(1, 8'h33, "t1_p3");
    pop(1, 8'h0D, "t1_p4");
    chk("t1_empty", 32'(vld_out), 32'd0);
    chk("t1_err_cnt", 32'(err_seen), 32'd0);

    // Same packet with bad parity 00: delivered whole, one err pulse
    send(8'h0D);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h00);
    chk("t2_err_check", 32'(err), 32'd0);
    tick;
    chk("t2_err_pulse", 32'(err), 32'd1);
    tick;
    chk("t2_err_end", 32'(err), 32'd0);
    pop(1, 8'h0D, "t2_p0");
    pop(1, 8'h11, "t2_p1");
    pop(1, 8'h22, "t2_p2");
    pop(1, 8'h33, "t2_p3");
    pop(1, 8'h00, "t2_p4");
    chk("t2_err_cnt", 32'(err_seen), 32'd1);

    // Invalid address 3, L=1: dropped, never busy, one err pulse
    send(8'h07);
    chk("t3_busy_a", 32'(busy), 32'd0);
    chk("t3_vld_a", 32'(vld_out), 32'd0);
    send(8'h55);
    chk("t3_busy_b", 32'(busy), 32'd0);
    send(8'h52);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_vld_b", 32'(vld_out), 32'd0);
    send(8'h04);
    send(8'hAA);
    send(8'hAE);
    chk("t3_vld_port0", 32'(vld_out), 32'b001);
    tick;
    tick;
    chk("t3_err_cnt", 32'(err_seen), 32'd2);
    pop(0, 8'h04, "t3_p0");
    pop(0, 8'hAA, "t3_p1");
    pop(0, 8'hAE, "t3_p2");

    // Port 0, L=20: backpressure at 16 entries
    send(8'h50);
    for (int k = 1; k <= 15; k++) send(8'(k));
    pkt_valid = 1'b1;
    data_in   = 8'h10;
    #1;
    chk("t4_full_busy", 32'(busy), 32'd1);
    tick;
    chk("t4_still_busy", 32'(busy), 32'd1);
    chk("t4_head", 32'(lane(0)), 32'h50);
    read_enb[0] = 1'b1;
    tick;
    read_enb[0] = 1'b0;
    chk("t4_room", 32'(busy), 32'd0);
    chk("t4_head2", 32'(lane(0)), 32'h01);
    tick;
    chk("t4_full_again", 32'(busy), 32'd1);
    pkt_valid = 1'b0;
    for (int k = 1; k <= 16; k++) pop(0, 8'(k), "t4_drain");
    chk("t4_empty", 32'(vld_out), 32'd0);
    send(8'h11);
    send(8'h12);
    send(8'h13);
    send(8'h14);
    send(8'h44);
    tick;
    tick;
    chk("t4_err_cnt", 32'(err_seen), 32'd2);
    pop(0, 8'h11, "t4_t0");
    pop(0, 8'h12, "t4_t1");
    pop(0, 8'h13, "t4_t2");
    pop(0, 8'h14, "t4_t3");
    pop(0, 8'h44, "t4_t4");
    chk("t4_done", 32'(vld_out), 32'd0);

    // Timeout flush on port 2 after 30 unread cycles
    send(8'h02);
    chk("t5_vld", 32'(vld_out), 32'b100);
    send(8'h02);
    repeat (28) tick;
    chk("t5_vld_c29", 32'(vld_out), 32'b100);
    tick;
    chk("t5_flushed", 32'(vld_out), 32'd0);
    chk("t5_hold", 32'(lane(2)), 32'h02);

    // Read at cycle 29 restarts the timer: no flush
    send(8'h02);
    send(8'h02);
    repeat (27) tick;
    read_enb[2] = 1'b1;
    tick;
    read_enb[2] = 1'b0;
    chk("t5b_vld_c30", 32'(vld_out), 32'b100);
    tick;
    chk("t5b_vld_c31", 32'(vld_out), 32'b100);
    pop(2, 8'h02, "t5b_last");
    chk("t5b_empty", 32'(vld_out), 32'd0);
    chk("t5_err_cnt", 32'(err_seen), 32'd2);

    // Reset mid-payload, then a fresh packet to port 2
    send(8'h0D);
    send(8'h11);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t6_vld", 32'(vld_out), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_dout", 32'(data_out), 32'd0);
    send(8'h06);
    send(8'h77);
    send(8'h71);
    chk("t6_vld_port2", 32'(vld_out), 32'b100);
    tick;
    tick;
    chk("t6_err_cnt", 32'(err_seen), 32'd2);
    pop(2, 8'h06, "t6_p0");
    pop(2, 8'h77, "t6_p1");
    pop(2, 8'h71, "t6_p2");
    chk("t6_empty", 32'(vld_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
